// File: rtl/axis_frame_selector.sv
`default_nettype none
// ============================================================================
//  Module   : axis_frame_selector
//  Purpose  : AXI4-Stream N-way lane selector. Picks one packed lane per beat,
//             switches lanes only at frame boundaries and flags frame ends
//             with tlast. Output register plus skid register give full
//             throughput with a registered s_axis_tready.
//  Revision : 1.0  initial release
// ============================================================================
module axis_frame_selector #(
    parameter int CHANNELS   = 8,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 3,
    parameter int CNTR_WIDTH = 16
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [SEL_WIDTH-1:0]           cfg_sel,
    input  logic [CNTR_WIDTH-1:0]          cfg_frame,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [SEL_WIDTH-1:0]           sts_sel,
    output logic [31:0]                    sts_frames
);

    // Frame tracking
    logic [CNTR_WIDTH-1:0] r_cnt;
    logic [SEL_WIDTH-1:0]  r_active_sel;
    logic [31:0]           r_frames;

    // Output (O) and skid (K) registers
    logic [DATA_WIDTH-1:0] r_o_data;
    logic                  r_o_last;
    logic                  r_o_valid;
    logic [DATA_WIDTH-1:0] r_k_data;
    logic                  r_k_last;
    logic                  r_k_valid;
    logic                  r_s_ready;

    logic                  w_accept;
    logic                  w_consume;
    logic [SEL_WIDTH-1:0]  w_sel;
    logic [CNTR_WIDTH:0]   w_cnt_inc;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_k_nxt;

    assign w_accept  = s_axis_tvalid && r_s_ready;
    assign w_consume = r_o_valid && m_axis_tready;

    // First beat of a frame samples the live request, the rest reuse the latched lane
    assign w_sel = (r_cnt == '0) ? cfg_sel : r_active_sel;

    // cnt+1 >= cfg_frame in one extra bit, so cfg_frame of 0 or 1 marks every beat last
    assign w_cnt_inc = {1'b0, r_cnt} + {{CNTR_WIDTH{1'b0}}, 1'b1};
    assign w_last    = (w_cnt_inc >= {1'b0, cfg_frame});

    // Lane mux; out-of-range lane indices yield zero data
    always_comb begin
        w_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_sel == SEL_WIDTH'(k)) begin
                w_data = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Skid occupancy after this edge: K only fills when O is full and held.
    // Accepts never coincide with a full K because s_axis_tready mirrors !K.
    assign w_k_nxt = !w_consume && (r_k_valid || (w_accept && r_o_valid));

    // Beat counter, lane latch and completed-frame count
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt        <= '0;
            r_active_sel <= '0;
            r_frames     <= '0;
        end else if (w_accept) begin
            if (r_cnt == '0) begin
                r_active_sel <= cfg_sel;
            end
            if (w_last) begin
                r_cnt    <= '0;
                r_frames <= r_frames + 32'd1;
            end else begin
                r_cnt <= r_cnt + {{(CNTR_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Output/skid datapath with registered input ready
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_o_data  <= '0;
            r_o_last  <= 1'b0;
            r_o_valid <= 1'b0;
            r_k_data  <= '0;
            r_k_last  <= 1'b0;
            r_k_valid <= 1'b0;
            r_s_ready <= 1'b0;
        end else begin
            if (w_consume) begin
                if (r_k_valid) begin
                    r_o_data <= r_k_data;
                    r_o_last <= r_k_last;
                end else if (w_accept) begin
                    r_o_data <= w_data;
                    r_o_last <= w_last;
                end else begin
                    r_o_valid <= 1'b0;
                end
            end else if (w_accept) begin
                if (!r_o_valid) begin
                    r_o_data  <= w_data;
                    r_o_last  <= w_last;
                    r_o_valid <= 1'b1;
                end else begin
                    r_k_data <= w_data;
                    r_k_last <= w_last;
                end
            end
            r_k_valid <= w_k_nxt;
            r_s_ready <= !w_k_nxt;
        end
    end

    assign s_axis_tready = r_s_ready;
    assign m_axis_tdata  = r_o_data;
    assign m_axis_tvalid = r_o_valid;
    assign m_axis_tlast  = r_o_last;
    assign sts_sel       = r_active_sel;
    assign sts_frames    = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_selector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_frame_selector
//  Purpose  : Directed self-checking bench for axis_frame_selector
//             (8-lane main instance plus a 6-lane instance for range checks).
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_frame_selector;

    logic         aclk;
    logic         aresetn;
    logic [2:0]   cfg_sel;
    logic [15:0]  cfg_frame;
    logic [255:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [2:0]   sts_sel;
    logic [31:0]  sts_frames;

    logic         s6_tready;
    logic [31:0]  m6_tdata;
    logic         m6_tvalid;
    logic         m6_tlast;
    logic [2:0]   sts6_sel;
    logic [31:0]  sts6_frames;

    int vectors;
    int miscompares;

    axis_frame_selector #(
        .CHANNELS(8), .DATA_WIDTH(32), .SEL_WIDTH(3), .CNTR_WIDTH(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_sel(cfg_sel), .cfg_frame(cfg_frame),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .sts_sel(sts_sel), .sts_frames(sts_frames)
    );

    axis_frame_selector #(
        .CHANNELS(6), .DATA_WIDTH(32), .SEL_WIDTH(3), .CNTR_WIDTH(16)
    ) dut6 (
        .aclk(aclk), .aresetn(aresetn), .cfg_sel(cfg_sel), .cfg_frame(cfg_frame),
        .s_axis_tdata(s_axis_tdata[191:0]), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s6_tready), .m_axis_tdata(m6_tdata),
        .m_axis_tvalid(m6_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m6_tlast), .sts_sel(sts6_sel), .sts_frames(sts6_frames)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [31:0] lane(input int k, input int n);
        return 32'(k) * 32'h1000_0000 + 32'(n);
    endfunction

    function automatic logic [255:0] mk(input int n);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = lane(k, n);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int sent, rcv, cyc, frames_exp;
        int sels[8];
        vectors = 0; miscompares = 0;
        aresetn = 1'b0; cfg_sel = 3'd5; cfg_frame = 16'd4;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;

        // Power-on reset state
        tick(); tick();
        chk("rst_ready", 64'(s_axis_tready), 64'd0);
        chk("rst_valid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_data", 64'(m_axis_tdata), 64'd0);
        chk("rst_frames", 64'(sts_frames), 64'd0);
        aresetn = 1'b1;
        #1 chk("ready_before_edge", 64'(s_axis_tready), 64'd0);
        tick();
        chk("ready_after_release", 64'(s_axis_tready), 64'd1);

        // Basic selection, lane 5, 4-beat frames
        for (int n = 0; n < 12; n++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = mk(n);
            tick();
            chk("basic_data", 64'(m_axis_tdata), 64'(lane(5, n)));
            chk("basic_last", 64'(m_axis_tlast), 64'((n % 4) == 3));
            chk("basic_frames", 64'(sts_frames), 64'((n + 1) / 4));
        end

        // Mid-frame switch 5 -> 2 during beat 1
        for (int n = 0; n < 8; n++) begin
            cfg_sel = (n >= 1) ? 3'd2 : 3'd5;
            s_axis_tdata = mk(n);
            tick();
            chk("switch_data", 64'(m_axis_tdata), 64'(lane((n >= 4) ? 2 : 5, n)));
            chk("switch_sts_sel", 64'(sts_sel), 64'((n >= 4) ? 2 : 5));
            chk("switch_frames", 64'(sts_frames), 64'(3 + (n + 1) / 4));
        end
        s_axis_tvalid = 1'b0;
        tick();
        chk("valid_drop", 64'(m_axis_tvalid), 64'd0);

        // Backpressure: 12 beats, tready low for cycles 0..2 and 6..7
        sent = 0; rcv = 0; cyc = 0;
        while (rcv < 12 && cyc < 60) begin
            m_axis_tready = !(cyc < 3 || cyc == 6 || cyc == 7);
            s_axis_tvalid = (sent < 12);
            s_axis_tdata  = mk(sent);
            if (cyc == 2) begin
                chk("bp_ready_low", 64'(s_axis_tready), 64'd0);
                chk("bp_hold_data", 64'(m_axis_tdata), 64'(lane(2, 0)));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                chk("bp_data", 64'(m_axis_tdata), 64'(lane(2, rcv)));
                chk("bp_last", 64'(m_axis_tlast), 64'((rcv % 4) == 3));
                rcv++;
            end
            if (s_axis_tvalid && s_axis_tready) sent++;
            tick();
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        chk("bp_count", 64'(rcv), 64'd12);
        chk("bp_no_extra", 64'(m_axis_tvalid), 64'd0);
        chk("bp_frames", 64'(sts_frames), 64'd8);

        // Edge configuration: frame length 0 then 1, lane resampled per beat
        sels = '{1, 3, 6, 7, 7, 0, 5, 2};
        frames_exp = 8;
        for (int i = 0; i < 8; i++) begin
            cfg_frame = (i < 4) ? 16'd0 : 16'd1;
            cfg_sel = 3'(sels[i]);
            s_axis_tvalid = 1'b1; s_axis_tdata = mk(i);
            tick();
            frames_exp++;
            chk("edge_data", 64'(m_axis_tdata), 64'(lane(sels[i], i)));
            chk("edge_last", 64'(m_axis_tlast), 64'd1);
            chk("edge_sts_sel", 64'(sts_sel), 64'(sels[i]));
            chk("edge_frames", 64'(sts_frames), 64'(frames_exp));
            chk("ch6_data", 64'(m6_tdata), (sels[i] < 6) ? 64'(lane(sels[i], i)) : 64'd0);
            chk("ch6_last", 64'(m6_tlast), 64'd1);
            chk("ch6_valid", 64'(m6_tvalid), 64'd1);
            chk("ch6_ready", 64'(s6_tready), 64'd1);
            chk("ch6_sts_sel", 64'(sts6_sel), 64'(sels[i]));
            chk("ch6_frames", 64'(sts6_frames), 64'(frames_exp));
        end

        // Live frame shrink 8 -> 3 at cnt=5
        cfg_sel = 3'd3;
        for (int n = 0; n < 9; n++) begin
            cfg_frame = (n >= 5) ? 16'd3 : 16'd8;
            s_axis_tdata = mk(n);
            tick();
            chk("shrink_data", 64'(m_axis_tdata), 64'(lane(3, n)));
            chk("shrink_last", 64'(m_axis_tlast), 64'(n == 5 || n == 8));
            chk("shrink_frames", 64'(sts_frames), 64'(16 + ((n >= 5) ? 1 : 0) + ((n >= 8) ? 1 : 0)));
        end

        // Reset mid-traffic with O and K both full
        cfg_frame = 16'd4;
        m_axis_tready = 1'b0;
        s_axis_tdata = mk(20); tick();
        s_axis_tdata = mk(21); tick();
        chk("pre_rst_ready", 64'(s_axis_tready), 64'd0);
        #3 aresetn = 1'b0;
        #1;
        chk("midrst_valid", 64'(m_axis_tvalid), 64'd0);
        chk("midrst_data", 64'(m_axis_tdata), 64'd0);
        chk("midrst_last", 64'(m_axis_tlast), 64'd0);
        chk("midrst_ready", 64'(s_axis_tready), 64'd0);
        chk("midrst_sts_sel", 64'(sts_sel), 64'd0);
        chk("midrst_frames", 64'(sts_frames), 64'd0);
        s_axis_tvalid = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        chk("rerelease_ready", 64'(s_axis_tready), 64'd1);
        cfg_sel = 3'd4; cfg_frame = 16'd2; m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1; s_axis_tdata = mk(0);
        tick();
        chk("post_rst_data0", 64'(m_axis_tdata), 64'(lane(4, 0)));
        chk("post_rst_last0", 64'(m_axis_tlast), 64'd0);
        chk("post_rst_sts_sel", 64'(sts_sel), 64'd4);
        cfg_sel = 3'd1; s_axis_tdata = mk(1);
        tick();
        chk("post_rst_data1", 64'(m_axis_tdata), 64'(lane(4, 1)));
        chk("post_rst_last1", 64'(m_axis_tlast), 64'd1);
        chk("post_rst_frames", 64'(sts_frames), 64'd1);
        s_axis_tvalid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
